demux1n_stream: RTL and testbench

Registered, parametrised 1:N stream demultiplexer with a valid/ready handshake on the input and on every output channel. It routes each accepted input word into a one-deep output register on the channel chosen either by the select input or by an internal round-robin pointer. It is the sequential, back-pressure-aware successor of the team's combinational 1:4 demux and sits between a single producer and N independent consumers.

---
 rtl/demux1n_stream.sv | 61 ++++++
 tb/tb_demux1n_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux1n_stream.sv
// Registered 1:N stream demultiplexer: each accepted word lands in a one-deep
// register on the channel picked by s (MODE 0) or a round-robin pointer (MODE 1).
module demux1n_stream #(
  parameter int DW   = 8,
  parameter int SW   = 2,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           i,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [SW-1:0]           s,
  output logic [(2**SW)*DW-1:0]   y,
  output logic [2**SW-1:0]        y_valid,
  input  logic [2**SW-1:0]        y_ready,
  output logic [SW-1:0]           tgt
);

  localparam int N = 2**SW;

  // Handshake: a word moves on a port in every cycle where its valid and ready
  // are both high at the rising edge; valid never depends on ready.
  logic [DW-1:0] r_d [N];
  logic [N-1:0]  r_v;
  logic [SW-1:0] r_rr;

  logic [SW-1:0] w_tgt;
  logic          w_accept;

  assign w_tgt    = (MODE == 1) ? r_rr : s;
  assign tgt      = w_tgt;
  assign i_ready  = ~r_v[w_tgt] | y_ready[w_tgt];
  assign w_accept = i_valid & i_ready;
  assign y_valid  = r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_rr <= '0;
      for (int k = 0; k < N; k++) r_d[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        // Refill wins over drain so a same-cycle drain/refill leaves no bubble.
        if (w_accept && (w_tgt == SW'(k))) begin
          r_d[k] <= i;
          r_v[k] <= 1'b1;
        end else if (r_v[k] && y_ready[k]) begin
          r_v[k] <= 1'b0;
        end
      end
      if ((MODE == 1) && w_accept) r_rr <= r_rr + 1'b1;
    end
  end

  // Empty channels read as zero so stale data never leaks to a consumer.
  for (genvar g = 0; g < N; g++) begin : g_out
    assign y[g*DW +: DW] = r_v[g] ? r_d[g] : '0;
  end

endmodule

// File: tb/tb_demux1n_stream.sv
// Bench for demux1n_stream: directed vector tables on two 8-bit/4-channel
// instances, reset corner case, and random scoreboards on SW=1/DW=1 and SW=3/DW=16.
module tb_demux1n_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: MODE 0, DW 8, SW 2
  logic [7:0]  i0 = '0;  logic v0 = 1'b0; logic [1:0] s0 = '0; logic ir0;
  logic [31:0] y0; logic [3:0] yv0; logic [3:0] yr0 = '0; logic [1:0] tgt0;
  // dut1: MODE 1, DW 8, SW 2
  logic [7:0]  i1 = '0;  logic v1 = 1'b0; logic [1:0] s1 = '0; logic ir1;
  logic [31:0] y1; logic [3:0] yv1; logic [3:0] yr1 = '0; logic [1:0] tgt1;
  // dut2: MODE 1, DW 1, SW 1
  logic [0:0]  i2 = '0;  logic v2 = 1'b0; logic [0:0] s2 = '0; logic ir2;
  logic [1:0]  y2; logic [1:0] yv2; logic [1:0] yr2 = '0; logic [0:0] tgt2;
  // dut3: MODE 0, DW 16, SW 3
  logic [15:0] i3 = '0;  logic v3 = 1'b0; logic [2:0] s3 = '0; logic ir3;
  logic [127:0] y3; logic [7:0] yv3; logic [7:0] yr3 = '0; logic [2:0] tgt3;

  demux1n_stream #(.DW(8), .SW(2), .MODE(0)) dut0 (.clk(clk), .rst(rst), .i(i0), .i_valid(v0),
    .i_ready(ir0), .s(s0), .y(y0), .y_valid(yv0), .y_ready(yr0), .tgt(tgt0));
  demux1n_stream #(.DW(8), .SW(2), .MODE(1)) dut1 (.clk(clk), .rst(rst), .i(i1), .i_valid(v1),
    .i_ready(ir1), .s(s1), .y(y1), .y_valid(yv1), .y_ready(yr1), .tgt(tgt1));
  demux1n_stream #(.DW(1), .SW(1), .MODE(1)) dut2 (.clk(clk), .rst(rst), .i(i2), .i_valid(v2),
    .i_ready(ir2), .s(s2), .y(y2), .y_valid(yv2), .y_ready(yr2), .tgt(tgt2));
  demux1n_stream #(.DW(16), .SW(3), .MODE(0)) dut3 (.clk(clk), .rst(rst), .i(i3), .i_valid(v3),
    .i_ready(ir3), .s(s3), .y(y3), .y_valid(yv3), .y_ready(yr3), .tgt(tgt3));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  i;
    logic        v;
    logic [1:0]  s;
    logic [3:0]  yr;
    logic        e_ir;
    logic [3:0]  e_yv;
    logic [31:0] e_y;
    logic [1:0]  e_tgt;
  } vec_t;

  vec_t tab0[18];
  vec_t tab1[21];

  logic [15:0] exp3_q [8][$];
  logic [0:0]  exp2_q [2][$];

  function automatic vec_t mk(logic [7:0] i, logic v, logic [1:0] s, logic [3:0] yr,
                              logic e_ir, logic [3:0] e_yv, logic [31:0] e_y, logic [1:0] e_tgt);
    vec_t t;
    t.i = i; t.v = v; t.s = s; t.yr = yr;
    t.e_ir = e_ir; t.e_yv = e_yv; t.e_y = e_y; t.e_tgt = e_tgt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one table row after the edge, check outputs on the falling edge.
  task automatic run_vec(input vec_t t, input int which, input int idx);
    @(posedge clk); #1;
    if (which == 0) begin
      i0 = t.i; v0 = t.v; s0 = t.s; yr0 = t.yr;
    end else begin
      i1 = t.i; v1 = t.v; s1 = t.s; yr1 = t.yr;
    end
    @(negedge clk);
    if (which == 0) begin
      chk($sformatf("t0[%0d].i_ready", idx), {127'd0, ir0}, {127'd0, t.e_ir});
      chk($sformatf("t0[%0d].y_valid", idx), {124'd0, yv0}, {124'd0, t.e_yv});
      chk($sformatf("t0[%0d].y", idx), {96'd0, y0}, {96'd0, t.e_y});
      chk($sformatf("t0[%0d].tgt", idx), {126'd0, tgt0}, {126'd0, t.e_tgt});
    end else begin
      chk($sformatf("t1[%0d].i_ready", idx), {127'd0, ir1}, {127'd0, t.e_ir});
      chk($sformatf("t1[%0d].y_valid", idx), {124'd0, yv1}, {124'd0, t.e_yv});
      chk($sformatf("t1[%0d].y", idx), {96'd0, y1}, {96'd0, t.e_y});
      chk($sformatf("t1[%0d].tgt", idx), {126'd0, tgt1}, {126'd0, t.e_tgt});
    end
  endtask

  initial begin
    logic [127:0] ey3;
    logic [7:0]   eyv3;
    logic [1:0]   ey2;
    logic [1:0]   eyv2;
    logic         e_ir;
    logic         acc2;
    logic         acc3;
    logic [0:0]   m_rr2;

    // MODE 0: select routing, back-pressure, drain/refill, independence
    tab0[0]  = mk(8'h11, 1, 0, 4'b0000, 1, 4'b0000, 32'h00000000, 0);
    tab0[1]  = mk(8'h22, 1, 1, 4'b0000, 1, 4'b0001, 32'h00000011, 1);
    tab0[2]  = mk(8'h33, 1, 2, 4'b0000, 1, 4'b0011, 32'h00002211, 2);
    tab0[3]  = mk(8'h44, 1, 3, 4'b0000, 1, 4'b0111, 32'h00332211, 3);
    tab0[4]  = mk(8'h55, 1, 1, 4'b0000, 0, 4'b1111, 32'h44332211, 1);
    tab0[5]  = mk(8'h55, 1, 1, 4'b0000, 0, 4'b1111, 32'h44332211, 1);
    tab0[6]  = mk(8'h55, 1, 1, 4'b0010, 1, 4'b1111, 32'h44332211, 1);
    tab0[7]  = mk(8'h00, 0, 0, 4'b0000, 0, 4'b1111, 32'h44335511, 0);
    tab0[8]  = mk(8'h5A, 1, 2, 4'b0100, 1, 4'b1111, 32'h44335511, 2);
    tab0[9]  = mk(8'hC3, 1, 2, 4'b0100, 1, 4'b1111, 32'h445A5511, 2);
    tab0[10] = mk(8'h00, 0, 2, 4'b0000, 0, 4'b1111, 32'h44C35511, 2);
    tab0[11] = mk(8'h00, 0, 0, 4'b1111, 1, 4'b1111, 32'h44C35511, 0);
    tab0[12] = mk(8'h77, 1, 0, 4'b0000, 1, 4'b0000, 32'h00000000, 0);
    tab0[13] = mk(8'h99, 1, 3, 4'b0001, 1, 4'b0001, 32'h00000077, 3);
    tab0[14] = mk(8'h00, 0, 0, 4'b0000, 1, 4'b1000, 32'h99000000, 0);
    tab0[15] = mk(8'h00, 0, 3, 4'b0110, 0, 4'b1000, 32'h99000000, 3);
    tab0[16] = mk(8'h00, 0, 3, 4'b1000, 1, 4'b1000, 32'h99000000, 3);
    tab0[17] = mk(8'h00, 0, 0, 4'b0000, 1, 4'b0000, 32'h00000000, 0);

    // MODE 1: round-robin wrap at full rate, then stall on a blocked channel 1
    tab1[0]  = mk(8'h01, 1, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0);
    tab1[1]  = mk(8'h02, 1, 0, 4'b1111, 1, 4'b0001, 32'h00000001, 1);
    tab1[2]  = mk(8'h03, 1, 0, 4'b1111, 1, 4'b0010, 32'h00000200, 2);
    tab1[3]  = mk(8'h04, 1, 0, 4'b1111, 1, 4'b0100, 32'h00030000, 3);
    tab1[4]  = mk(8'h05, 1, 0, 4'b1111, 1, 4'b1000, 32'h04000000, 0);
    tab1[5]  = mk(8'h06, 1, 0, 4'b1111, 1, 4'b0001, 32'h00000005, 1);
    tab1[6]  = mk(8'h07, 1, 0, 4'b1111, 1, 4'b0010, 32'h00000600, 2);
    tab1[7]  = mk(8'h08, 1, 0, 4'b1111, 1, 4'b0100, 32'h00070000, 3);
    tab1[8]  = mk(8'h09, 1, 0, 4'b1111, 1, 4'b1000, 32'h08000000, 0);
    tab1[9]  = mk(8'h00, 0, 0, 4'b1111, 1, 4'b0001, 32'h00000009, 1);
    tab1[10] = mk(8'h0A, 1, 0, 4'b1101, 1, 4'b0000, 32'h00000000, 1);
    tab1[11] = mk(8'h0B, 1, 0, 4'b1101, 1, 4'b0010, 32'h00000A00, 2);
    tab1[12] = mk(8'h0C, 1, 0, 4'b1101, 1, 4'b0110, 32'h000B0A00, 3);
    tab1[13] = mk(8'h0D, 1, 0, 4'b1101, 1, 4'b1010, 32'h0C000A00, 0);
    tab1[14] = mk(8'h0E, 1, 0, 4'b1101, 0, 4'b0011, 32'h00000A0D, 1);
    tab1[15] = mk(8'h0E, 1, 0, 4'b1101, 0, 4'b0010, 32'h00000A00, 1);
    tab1[16] = mk(8'h0E, 1, 0, 4'b1101, 0, 4'b0010, 32'h00000A00, 1);
    tab1[17] = mk(8'h0E, 1, 0, 4'b0010, 1, 4'b0010, 32'h00000A00, 1);
    tab1[18] = mk(8'h00, 0, 0, 4'b0000, 1, 4'b0010, 32'h00000E00, 2);
    tab1[19] = mk(8'h0F, 1, 0, 4'b0000, 1, 4'b0010, 32'h00000E00, 2);
    tab1[20] = mk(8'h10, 1, 0, 4'b0100, 1, 4'b0110, 32'h000F0E00, 3);

    // Clock/reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.y_valid0", {124'd0, yv0}, 128'd0);
    chk("reset.y1", {96'd0, y1}, 128'd0);
    chk("reset.i_ready1", {127'd0, ir1}, 128'd1);
    chk("reset.y_valid3", {120'd0, yv3}, 128'd0);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) run_vec(tab0[k], 0, k);
    for (int k = 0; k < 21; k++) run_vec(tab1[k], 1, k);

    // Mid-stream async reset with dut1 channels 1 and 3 full
    @(posedge clk); #1;
    v1 = 1'b0; yr1 = '0;
    chk("pre_rst.y_valid1", {124'd0, yv1}, {124'd0, 4'b1010});
    #1 rst = 1'b1;
    #1;
    chk("rst.y_valid1", {124'd0, yv1}, 128'd0);
    chk("rst.y1", {96'd0, y1}, 128'd0);
    chk("rst.i_ready1", {127'd0, ir1}, 128'd1);
    chk("rst.tgt1", {126'd0, tgt1}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    i0 = 8'hA5; s0 = 2'd2; v0 = 1'b1;
    #1 chk("post_rst.i_ready0", {127'd0, ir0}, 128'd1);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("post_rst.y_valid0", {124'd0, yv0}, {124'd0, 4'b0100});
    chk("post_rst.y0", {96'd0, y0}, {96'd0, 32'h00A50000});

    // Random scoreboards on the SW=1/DW=1 and SW=3/DW=16 instances
    acc2 = 1'b0; acc3 = 1'b0; m_rr2 = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!(v2 && !acc2)) begin
        v2 = (c < 1400) && ($urandom_range(0, 9) < 7);
        i2 = 1'($urandom_range(0, 1));
      end
      s2  = 1'($urandom_range(0, 1));
      yr2 = (c < 1400) ? 2'($urandom_range(0, 3)) : 2'b11;
      if (!(v3 && !acc3)) begin
        v3 = (c < 1400) && ($urandom_range(0, 9) < 7);
        i3 = 16'($urandom_range(0, 65535));
        s3 = 3'($urandom_range(0, 7));
      end
      yr3 = (c < 1400) ? 8'($urandom_range(0, 255)) : 8'hFF;
      @(negedge clk);

      ey2 = '0; eyv2 = '0;
      for (int k = 0; k < 2; k++)
        if (exp2_q[k].size() != 0) begin eyv2[k] = 1'b1; ey2[k] = exp2_q[k][0]; end
      e_ir = !eyv2[m_rr2] || yr2[m_rr2];
      chk("rnd2.y_valid", {126'd0, yv2}, {126'd0, eyv2});
      chk("rnd2.y", {126'd0, y2}, {126'd0, ey2});
      chk("rnd2.i_ready", {127'd0, ir2}, {127'd0, e_ir});
      chk("rnd2.tgt", {127'd0, tgt2}, {127'd0, m_rr2});
      for (int k = 0; k < 2; k++)
        if (eyv2[k] && yr2[k]) void'(exp2_q[k].pop_front());
      acc2 = v2 && e_ir;
      if (acc2) begin
        exp2_q[m_rr2].push_back(i2);
        m_rr2 = m_rr2 + 1'b1;
      end

      ey3 = '0; eyv3 = '0;
      for (int k = 0; k < 8; k++)
        if (exp3_q[k].size() != 0) begin eyv3[k] = 1'b1; ey3[k*16 +: 16] = exp3_q[k][0]; end
      e_ir = !eyv3[s3] || yr3[s3];
      chk("rnd3.y_valid", {120'd0, yv3}, {120'd0, eyv3});
      chk("rnd3.y", y3, ey3);
      chk("rnd3.i_ready", {127'd0, ir3}, {127'd0, e_ir});
      chk("rnd3.tgt", {125'd0, tgt3}, {125'd0, s3});
      for (int k = 0; k < 8; k++)
        if (eyv3[k] && yr3[k]) void'(exp3_q[k].pop_front());
      acc3 = v3 && e_ir;
      if (acc3) exp3_q[s3].push_back(i3);
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
